// File: rtl/va_gen_sweep_ctrl_if.sv
// Bus between the HPS/capture side and the sweep sequencer: control word, frequency setup, NCO load, measure handshake, status.
// Purely wiring, so it adds no latency.
// Backpressure comes only from meas_ack: the sequencer holds meas_req until the capture side accepts it.
`timescale 1ns/1ps
interface va_gen_sweep_ctrl_if #(
    parameter int FREQ_W = 32
);
    logic [31:0]       ctrl_word;
    logic [FREQ_W-1:0] f_start;
    logic [FREQ_W-1:0] f_step;
    logic [FREQ_W-1:0] freq_word;
    logic              freq_load;
    logic              meas_req;
    logic              meas_ack;
    logic [11:0]       point_idx;
    logic              busy;
    logic              done;
    logic              sweep_err;
    logic [31:0]       status;

    // Side that owns the control word and answers measurement requests.
    modport master (
        output ctrl_word, f_start, f_step, meas_ack,
        input  freq_word, freq_load, meas_req, point_idx, busy, done, sweep_err, status
    );

    // The sweep sequencer itself.
    modport slave (
        input  ctrl_word, f_start, f_step, meas_ack,
        output freq_word, freq_load, meas_req, point_idx, busy, done, sweep_err, status
    );
endinterface

// File: rtl/va_gen_sweep_ctrl.sv
// Sweep sequencer: steps the NCO word over N points, dwells, then handshakes one measurement per point.
// Start to first meas_req takes 2 + max(dwell,1) cycles. Every output is registered.
// meas_req is held until meas_ack. Optional ack timeout under macro VA_GEN_SWEEP_TIMEOUT_EN.
`timescale 1ns/1ps
module va_gen_sweep_ctrl #(
    parameter int FREQ_W = 32
`ifdef VA_GEN_SWEEP_TIMEOUT_EN
    ,
    parameter int TMO_W  = 20
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    va_gen_sweep_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_MEASURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            r_state, w_state;

    // Sweep configuration captured at the start edge.
    logic              r_cont,       w_cont;
    logic [11:0]       r_num_points, w_num_points;
    logic [15:0]       r_dwell,      w_dwell;

    // Sweep progress.
    logic [11:0]       r_idx,        w_idx;
    logic [15:0]       r_dwell_cnt,  w_dwell_cnt;

    // Registered outputs.
    logic [FREQ_W-1:0] r_freq_word,  w_freq_word;
    logic              r_freq_load,  w_freq_load;
    logic              r_meas_req,   w_meas_req;
    logic [11:0]       r_point_idx,  w_point_idx;
    logic              r_busy,       w_busy;
    logic              r_done,       w_done;
    logic              w_err_flag;

    logic              r_start_d;
    logic              w_start_edge;
    logic              w_abort;
    logic              w_last_point;
    logic              w_unused_rsvd;

`ifdef VA_GEN_SWEEP_TIMEOUT_EN
    logic              r_sweep_err,  w_sweep_err;
    logic [TMO_W-1:0]  r_tmo,        w_tmo;
    logic [TMO_W-1:0]  w_tmo_inc;

    assign w_tmo_inc  = r_tmo + TMO_W'(1);
    assign w_err_flag = r_sweep_err;
`else
    assign w_err_flag = 1'b0;
`endif

    // Only a rising edge of the start bit begins a sweep. Holding the bit high does not retrigger.
    assign w_start_edge  = bus.ctrl_word[0] & ~r_start_d;
    assign w_abort       = bus.ctrl_word[1];
    assign w_last_point  = (r_idx == (r_num_points - 12'd1));
    assign w_unused_rsvd = bus.ctrl_word[3];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Next-state and next-output logic. Abort overrides everything else.
    always_comb begin
        w_state      = r_state;
        w_cont       = r_cont;
        w_num_points = r_num_points;
        w_dwell      = r_dwell;
        w_idx        = r_idx;
        w_dwell_cnt  = r_dwell_cnt;
        w_freq_word  = r_freq_word;
        w_freq_load  = 1'b0;
        w_meas_req   = r_meas_req;
        w_point_idx  = r_point_idx;
        w_busy       = r_busy;
        w_done       = r_done;
`ifdef VA_GEN_SWEEP_TIMEOUT_EN
        w_sweep_err  = r_sweep_err;
        w_tmo        = r_tmo;
`endif

        if (w_abort) begin
            // freq_word keeps its last value so the NCO does not jump on abort.
            w_state    = S_IDLE;
            w_busy     = 1'b0;
            w_meas_req = 1'b0;
            w_done     = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        w_done       = 1'b0;
`ifdef VA_GEN_SWEEP_TIMEOUT_EN
                        w_sweep_err  = 1'b0;
`endif
                        w_idx        = 12'd0;
                        w_cont       = bus.ctrl_word[2];
                        w_num_points = bus.ctrl_word[15:4];
                        w_dwell      = bus.ctrl_word[31:16];
                        if (bus.ctrl_word[15:4] == 12'd0) begin
                            // Empty sweep: report completion without touching the NCO.
                            w_done  = 1'b1;
                            w_state = S_DONE;
                        end else begin
                            w_busy  = 1'b1;
                            w_state = S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    // f_start/f_step are read live here. The add wraps modulo 2^FREQ_W.
                    w_freq_word = (r_idx == 12'd0) ? bus.f_start : (r_freq_word + bus.f_step);
                    w_freq_load = 1'b1;
                    w_point_idx = r_idx;
                    w_busy      = 1'b1;
                    // A zero dwell still gives one settle cycle.
                    w_dwell_cnt = (r_dwell == 16'd0) ? 16'd0 : (r_dwell - 16'd1);
                    w_state     = S_SETTLE;
                end

                S_SETTLE: begin
                    if (r_dwell_cnt == 16'd0) begin
                        w_meas_req = 1'b1;
`ifdef VA_GEN_SWEEP_TIMEOUT_EN
                        w_tmo      = '0;
`endif
                        w_state    = S_MEASURE;
                    end else begin
                        w_dwell_cnt = r_dwell_cnt - 16'd1;
                    end
                end

                S_MEASURE: begin
                    if (bus.meas_ack) begin
                        w_meas_req = 1'b0;
                        if (!w_last_point) begin
                            w_idx   = r_idx + 12'd1;
                            w_state = S_LOAD;
                        end else if (r_cont && bus.ctrl_word[0]) begin
                            // Continuous mode wraps to point 0, which reloads f_start.
                            w_idx   = 12'd0;
                            w_state = S_LOAD;
                        end else begin
                            w_busy  = 1'b0;
                            w_done  = 1'b1;
                            w_state = S_DONE;
                        end
                    end
`ifdef VA_GEN_SWEEP_TIMEOUT_EN
                    else if (&w_tmo_inc) begin
                        // The capture block never answered, so end the sweep with an error.
                        w_meas_req  = 1'b0;
                        w_sweep_err = 1'b1;
                        w_busy      = 1'b0;
                        w_done      = 1'b1;
                        w_state     = S_DONE;
                    end else begin
                        w_tmo = w_tmo_inc;
                    end
`endif
                end

                S_DONE: begin
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                end

                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_d    <= 1'b0;
            r_cont       <= 1'b0;
            r_num_points <= 12'd0;
            r_dwell      <= 16'd0;
            r_idx        <= 12'd0;
            r_dwell_cnt  <= 16'd0;
            r_freq_word  <= '0;
            r_freq_load  <= 1'b0;
            r_meas_req   <= 1'b0;
            r_point_idx  <= 12'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_start_d    <= bus.ctrl_word[0];
            r_cont       <= w_cont;
            r_num_points <= w_num_points;
            r_dwell      <= w_dwell;
            r_idx        <= w_idx;
            r_dwell_cnt  <= w_dwell_cnt;
            r_freq_word  <= w_freq_word;
            r_freq_load  <= w_freq_load;
            r_meas_req   <= w_meas_req;
            r_point_idx  <= w_point_idx;
            r_busy       <= w_busy;
            r_done       <= w_done;
        end
    end

`ifdef VA_GEN_SWEEP_TIMEOUT_EN
    // Ack timeout counter and the sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo       <= '0;
            r_sweep_err <= 1'b0;
        end else begin
            r_tmo       <= w_tmo;
            r_sweep_err <= w_sweep_err;
        end
    end
`endif

    assign bus.freq_word = r_freq_word;
    assign bus.freq_load = r_freq_load;
    assign bus.meas_req  = r_meas_req;
    assign bus.point_idx = r_point_idx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.sweep_err = w_err_flag;
    assign bus.status    = {r_done, r_busy, w_err_flag, 13'b0, 4'b0, r_point_idx};

endmodule

// File: tb/tb_va_gen_sweep_ctrl.sv
// Directed bench for va_gen_sweep_ctrl. It covers reset, basic sweep, wrap, empty sweep, same-cycle ack, abort, continuous mode, held start and missing ack.
// Inputs are driven and outputs sampled 1 ns after each rising edge. Cycle 0 is the cycle in which start is raised.
// Expected values are worked out by hand from the sweep timing: one LOAD cycle, then dwell SETTLE cycles, then MEASURE until ack.
`timescale 1ns/1ps
module tb_va_gen_sweep_ctrl;
    localparam int FREQ_W = 32;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    va_gen_sweep_ctrl_if #(.FREQ_W(FREQ_W)) bus ();

`ifdef VA_GEN_SWEEP_TIMEOUT_EN
    va_gen_sweep_ctrl #(.FREQ_W(FREQ_W), .TMO_W(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`else
    va_gen_sweep_ctrl #(.FREQ_W(FREQ_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

    int n_vec = 0;
    int n_err = 0;

    // Observations from the latest run_sweep.
    logic [31:0] obs_fw  [16];
    logic [11:0] obs_idx [16];
    int obs_nload, obs_nreq, obs_first_req, obs_req_cycles, obs_done_cycle;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ctrl(input logic [15:0] dwell, input logic [11:0] n, input logic cont);
        return {dwell, n, 1'b0, cont, 1'b0, 1'b1};
    endfunction

    // Raise start in cycle 0 and run up to budget cycles, or until done is seen.
    // Start is dropped once clr_at freq_loads have been seen. ack_mode 0: never ack; 1: ack one cycle after req; 2: ack always high.
    task automatic run_sweep(input logic [31:0] ctrl, input int clr_at, input int ack_mode, input int budget);
        int  age;
        bit  prev_req;
        obs_nload = 0; obs_nreq = 0; obs_first_req = -1; obs_req_cycles = 0; obs_done_cycle = 0;
        age = 0; prev_req = 1'b0;
        bus.ctrl_word = ctrl;
        bus.meas_ack  = (ack_mode == 2);
        for (int c = 1; c <= budget; c++) begin
            step();
            if (bus.freq_load && obs_nload < 16) begin
                obs_fw[obs_nload]  = bus.freq_word;
                obs_idx[obs_nload] = bus.point_idx;
                obs_nload++;
            end
            if (bus.meas_req && !prev_req) begin
                obs_nreq++;
                if (obs_first_req < 0) obs_first_req = c;
            end
            if (bus.meas_req) obs_req_cycles++;
            prev_req = bus.meas_req;
            if (ack_mode == 1) begin
                if (bus.meas_req) begin
                    bus.meas_ack = (age == 1);
                    age++;
                end else begin
                    bus.meas_ack = 1'b0;
                    age = 0;
                end
            end
            if (obs_nload >= clr_at) bus.ctrl_word[0] = 1'b0;
            if (bus.done) begin
                obs_done_cycle = c;
                break;
            end
        end
        bus.meas_ack = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        bus.ctrl_word = 32'h0;
        bus.meas_ack  = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.ctrl_word = 32'h0; bus.f_start = '0; bus.f_step = '0; bus.meas_ack = 1'b0;
        step(); step(); step();
        n_vec++; if (bus.freq_word !== 32'h0) begin n_err++; $display("FAIL reset_freq_word: got %0h want 0", bus.freq_word); end
        n_vec++; if (bus.freq_load !== 1'b0) begin n_err++; $display("FAIL reset_freq_load: got %0b want 0", bus.freq_load); end
        n_vec++; if (bus.meas_req !== 1'b0) begin n_err++; $display("FAIL reset_meas_req: got %0b want 0", bus.meas_req); end
        n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sweep_err !== 1'b0) begin n_err++; $display("FAIL reset_flags: got busy=%0b done=%0b err=%0b want 0", bus.busy, bus.done, bus.sweep_err); end
        n_vec++; if (bus.status !== 32'h0) begin n_err++; $display("FAIL reset_status: got %0h want 0", bus.status); end
        reset_n = 1'b1;
        step(); step();
    endtask

    task automatic test_basic();
        bus.f_start = 32'd1000; bus.f_step = 32'd10;
        run_sweep(mk_ctrl(16'd4, 12'd3, 1'b0), 0, 1, 100);
        n_vec++; if (obs_first_req !== 6) begin n_err++; $display("FAIL basic_first_req: got %0d want 6", obs_first_req); end
        n_vec++; if (obs_nload !== 3) begin n_err++; $display("FAIL basic_nload: got %0d want 3", obs_nload); end
        n_vec++; if (obs_nreq !== 3) begin n_err++; $display("FAIL basic_nreq: got %0d want 3", obs_nreq); end
        n_vec++; if (obs_fw[0] !== 32'd1000 || obs_fw[1] !== 32'd1010 || obs_fw[2] !== 32'd1020) begin n_err++; $display("FAIL basic_freqs: got %0d,%0d,%0d want 1000,1010,1020", obs_fw[0], obs_fw[1], obs_fw[2]); end
        n_vec++; if (obs_idx[2] !== 12'd2) begin n_err++; $display("FAIL basic_idx2: got %0d want 2", obs_idx[2]); end
        n_vec++; if (obs_done_cycle !== 22) begin n_err++; $display("FAIL basic_done_cycle: got %0d want 22", obs_done_cycle); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %0b want 0", bus.busy); end
        n_vec++; if (bus.status !== 32'h8000_0002) begin n_err++; $display("FAIL basic_status: got %0h want 80000002", bus.status); end
        idle_gap(3);
        n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL basic_done_level: got %0b want 1", bus.done); end
    endtask

    task automatic test_wrap();
        bus.f_start = 32'hFFFF_FFF0; bus.f_step = 32'h20;
        run_sweep(mk_ctrl(16'd1, 12'd2, 1'b0), 0, 1, 100);
        n_vec++; if (obs_fw[0] !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL wrap_fw0: got %0h want fffffff0", obs_fw[0]); end
        n_vec++; if (obs_fw[1] !== 32'h0000_0010) begin n_err++; $display("FAIL wrap_fw1: got %0h want 10", obs_fw[1]); end
        n_vec++; if (obs_first_req !== 3) begin n_err++; $display("FAIL wrap_first_req: got %0d want 3", obs_first_req); end
        n_vec++; if (obs_nreq !== 2) begin n_err++; $display("FAIL wrap_nreq: got %0d want 2", obs_nreq); end
        idle_gap(3);
    endtask

    task automatic test_zero_points();
        run_sweep(mk_ctrl(16'd5, 12'd0, 1'b0), 0, 1, 20);
        n_vec++; if (obs_done_cycle !== 1) begin n_err++; $display("FAIL zero_done_cycle: got %0d want 1", obs_done_cycle); end
        n_vec++; if (obs_nload !== 0 || obs_nreq !== 0) begin n_err++; $display("FAIL zero_activity: got load=%0d req=%0d want 0,0", obs_nload, obs_nreq); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %0b want 0", bus.busy); end
        idle_gap(3);
    endtask

    task automatic test_same_cycle_ack();
        bus.f_start = 32'd100; bus.f_step = 32'hFFFF_FFFF;
        run_sweep(mk_ctrl(16'd3, 12'd2, 1'b0), 0, 2, 100);
        n_vec++; if (obs_req_cycles !== 2) begin n_err++; $display("FAIL sameack_req_cycles: got %0d want 2", obs_req_cycles); end
        n_vec++; if (obs_first_req !== 5) begin n_err++; $display("FAIL sameack_first_req: got %0d want 5", obs_first_req); end
        n_vec++; if (obs_done_cycle !== 11) begin n_err++; $display("FAIL sameack_done_cycle: got %0d want 11", obs_done_cycle); end
        n_vec++; if (obs_fw[1] !== 32'd99) begin n_err++; $display("FAIL sameack_down_step: got %0d want 99", obs_fw[1]); end
        idle_gap(3);
    endtask

    task automatic test_abort();
        int nreq, nbusy, nload;
        bus.f_start = 32'd500; bus.f_step = 32'd7;
        run_sweep(mk_ctrl(16'd8, 12'd3, 1'b0), 0, 1, 15);
        n_vec++; if (obs_nload !== 2 || obs_nreq !== 1 || obs_done_cycle !== 0) begin n_err++; $display("FAIL abort_pre: got load=%0d req=%0d done_cycle=%0d want 2,1,0", obs_nload, obs_nreq, obs_done_cycle); end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL abort_pre_busy: got %0b want 1", bus.busy); end
        bus.ctrl_word = 32'h2;
        step();
        n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.meas_req !== 1'b0) begin n_err++; $display("FAIL abort_flags: got busy=%0b done=%0b req=%0b want 0,0,0", bus.busy, bus.done, bus.meas_req); end
        n_vec++; if (bus.freq_word !== 32'd507) begin n_err++; $display("FAIL abort_freq_hold: got %0d want 507", bus.freq_word); end
        nreq = 0; nbusy = 0; nload = 0;
        bus.ctrl_word = 32'h0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.meas_req) nreq++;
            if (bus.busy) nbusy++;
        end
        n_vec++; if (nreq !== 0 || nbusy !== 0) begin n_err++; $display("FAIL abort_quiet: got req=%0d busy=%0d cycles want 0,0", nreq, nbusy); end
        // A start edge in the same cycle as abort is dropped, and the held level does not retrigger afterwards.
        bus.ctrl_word = mk_ctrl(16'd8, 12'd3, 1'b0) | 32'h2;
        step();
        bus.ctrl_word = mk_ctrl(16'd8, 12'd3, 1'b0);
        nbusy = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.busy) nbusy++;
            if (bus.freq_load) nload++;
        end
        n_vec++; if (nbusy !== 0 || nload !== 0) begin n_err++; $display("FAIL abort_start_same_cycle: got busy=%0d load=%0d want 0,0", nbusy, nload); end
        idle_gap(2);
        run_sweep(mk_ctrl(16'd8, 12'd3, 1'b0), 0, 1, 100);
        n_vec++; if (obs_fw[0] !== 32'd500 || obs_idx[0] !== 12'd0) begin n_err++; $display("FAIL abort_restart: got fw=%0d idx=%0d want 500,0", obs_fw[0], obs_idx[0]); end
        n_vec++; if (obs_fw[2] !== 32'd514 || obs_done_cycle === 0) begin n_err++; $display("FAIL abort_restart_end: got fw2=%0d done_cycle=%0d want 514,nonzero", obs_fw[2], obs_done_cycle); end
        idle_gap(3);
    endtask

    task automatic test_continuous();
        bus.f_start = 32'd2000; bus.f_step = 32'd100;
        run_sweep(mk_ctrl(16'd1, 12'd2, 1'b1), 4, 1, 200);
        n_vec++; if (obs_nload !== 4 || obs_nreq !== 4) begin n_err++; $display("FAIL cont_counts: got load=%0d req=%0d want 4,4", obs_nload, obs_nreq); end
        n_vec++; if (obs_idx[0] !== 12'd0 || obs_idx[1] !== 12'd1 || obs_idx[2] !== 12'd0 || obs_idx[3] !== 12'd1) begin n_err++; $display("FAIL cont_idx: got %0d,%0d,%0d,%0d want 0,1,0,1", obs_idx[0], obs_idx[1], obs_idx[2], obs_idx[3]); end
        n_vec++; if (obs_fw[2] !== 32'd2000 || obs_fw[3] !== 32'd2100) begin n_err++; $display("FAIL cont_reload: got %0d,%0d want 2000,2100", obs_fw[2], obs_fw[3]); end
        n_vec++; if (obs_done_cycle !== 17) begin n_err++; $display("FAIL cont_done_cycle: got %0d want 17", obs_done_cycle); end
        idle_gap(3);
    endtask

    task automatic test_start_held();
        int nbusy, nload;
        bus.f_start = 32'd7; bus.f_step = 32'd1;
        run_sweep(mk_ctrl(16'd1, 12'd1, 1'b0), 99, 1, 50);
        n_vec++; if (obs_done_cycle !== 5) begin n_err++; $display("FAIL held_done_cycle: got %0d want 5", obs_done_cycle); end
        nbusy = 0; nload = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.busy) nbusy++;
            if (bus.freq_load) nload++;
        end
        n_vec++; if (nbusy !== 0 || nload !== 0) begin n_err++; $display("FAIL held_no_retrigger: got busy=%0d load=%0d want 0,0", nbusy, nload); end
        idle_gap(3);
    endtask

    task automatic test_no_ack();
        bus.f_start = 32'd42; bus.f_step = 32'd1;
`ifdef VA_GEN_SWEEP_TIMEOUT_EN
        run_sweep(mk_ctrl(16'd2, 12'd1, 1'b0), 0, 0, 40);
        n_vec++; if (obs_req_cycles !== 15) begin n_err++; $display("FAIL tmo_req_cycles: got %0d want 15", obs_req_cycles); end
        n_vec++; if (obs_done_cycle !== 19) begin n_err++; $display("FAIL tmo_done_cycle: got %0d want 19", obs_done_cycle); end
        n_vec++; if (bus.sweep_err !== 1'b1 || bus.meas_req !== 1'b0) begin n_err++; $display("FAIL tmo_flags: got err=%0b req=%0b want 1,0", bus.sweep_err, bus.meas_req); end
        n_vec++; if (bus.status !== 32'hA000_0000) begin n_err++; $display("FAIL tmo_status: got %0h want a0000000", bus.status); end
`else
        run_sweep(mk_ctrl(16'd2, 12'd1, 1'b0), 0, 0, 40);
        n_vec++; if (obs_req_cycles !== 37 || bus.meas_req !== 1'b1) begin n_err++; $display("FAIL noack_req_held: got cycles=%0d req=%0b want 37,1", obs_req_cycles, bus.meas_req); end
        n_vec++; if (obs_done_cycle !== 0 || bus.sweep_err !== 1'b0) begin n_err++; $display("FAIL noack_no_end: got done_cycle=%0d err=%0b want 0,0", obs_done_cycle, bus.sweep_err); end
        n_vec++; if (bus.status !== 32'h4000_0000) begin n_err++; $display("FAIL noack_status: got %0h want 40000000", bus.status); end
        bus.ctrl_word = 32'h2;
        step();
        n_vec++; if (bus.meas_req !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL noack_abort: got req=%0b busy=%0b want 0,0", bus.meas_req, bus.busy); end
`endif
        idle_gap(3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_points();
        test_same_cycle_ack();
        test_abort();
        test_continuous();
        test_start_held();
        test_no_ack();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1);
    end
endmodule
